mem_fill_arbiter: RTL
=====================

Name: mem_fill_arbiter

Overview:
- Shares the single unified 16-bit main memory between the instruction-cache miss path and the data-cache miss/store path of the pipelined cpu.
- Grants one requester at a time and sequences block fills: BLOCK_WORDS address issues, then collection of the returned words.
- Performs single-cycle write-through stores.
- Sits between the I/D cache controllers and the memory model; pipeline stalls are driven by the caches while their request is pending.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- BLOCK_WORDS, 8, words per cache block; power of two; block size is 2*BLOCK_WORDS bytes.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_req  in  1  I-cache miss fill request; held until i_done.
- i_addr  in  ADDR_W  I-cache miss byte address.
- i_fill_we  out  1  I-cache fill word write strobe.
- i_fill_idx  out  log2(BLOCK_WORDS)  word index within block for i_fill_we.
- i_fill_data  out  DATA_W  fill word.
- i_done  out  1  pulse, last I-cache fill word.
- d_req  in  1  D-cache miss fill request; held until d_done.
- d_addr  in  ADDR_W  D-cache miss byte address.
- d_wr_req  in  1  store request; held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  DATA_W  store data.
- d_wr_ack  out  1  pulse, store issued.
- d_fill_we, d_fill_idx, d_fill_data, d_done  out  as I-side, for the D-cache.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en).
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  mem_rdata valid; returns in issue order, fixed pipelined latency.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - Issue and return counters clear.
  - All outputs are 0 from the following cycle.
- Reset mid-fill:
  - Abandons the fill; no done pulse is generated.
  - mem_rvalid is ignored until a new fill state is entered.
- States: IDLE, STORE, FILL_D, FILL_I.
- IDLE, fixed priority on the sampling edge:
  - d_wr_req -> STORE.
  - else d_req -> FILL_D.
  - else i_req -> FILL_I.
  - The granted address is latched on the transition edge. The block base is addr with the low log2(2*BLOCK_WORDS) bits cleared.
- STORE (one cycle):
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr latched, mem_wdata=latched data, d_wr_ack=1.
  - Next state is IDLE.
- FILL_x issue phase:
  - mem_en=1, mem_wr=0 for exactly BLOCK_WORDS consecutive cycles.
  - mem_addr = base + 2*issue_cnt; issue_cnt counts 0..BLOCK_WORDS-1.
  - Address arithmetic is modulo 2^ADDR_W; block 0xFFF0 issues 0xFFF0..0xFFFE, with no wrap beyond the block.
- FILL_x return phase, overlapping the issue phase:
  - On each mem_rvalid: x_fill_we=1, x_fill_idx=ret_cnt, x_fill_data=mem_rdata, then ret_cnt increments.
  - Only the granted side's strobes assert; the other side's outputs stay 0.
- Completion:
  - On the BLOCK_WORDS-th rvalid, x_done=1 in the same cycle as the last x_fill_we.
  - Next state is IDLE.
- Requester protocol:
  - A requester deasserts its req at the edge after its done/ack pulse.
  - A req still high at that edge is treated as a new request.
- A request arriving during a busy state waits. No preemption; a D request arriving mid-I-fill is served after it.
- Arbitration is strict D priority. Back-to-back D traffic may starve I, which is acceptable because the D side is older in program order.
- mem_rvalid while in IDLE or STORE is ignored.
- mem_en is 0 in IDLE and after the issue phase completes.
- Fill latency from the request sampling edge: first mem_en in the next cycle; done = 1 + (memory latency) + BLOCK_WORDS-1 cycles later.

Test Plan:
- Reset, then idle with no requests -> all outputs 0; mem_rvalid pulses are ignored with no fill strobes.
- i_req, i_addr=0x0046, memory latency 4 returning word (addr>>1) -> mem_addr 0x0040..0x004E on 8 consecutive cycles; i_fill_idx 0..7 with data 0x0020..0x0027; i_done on the 8th strobe; 12 cycles from grant to done.
- d_req and i_req asserted on the same edge -> D fill completes first; I fill's first mem_en follows the cycle after IDLE re-samples.
- d_wr_req (0x1234 -> 0x0100) with d_req pending -> one cycle of mem_en=1, mem_wr=1, mem_addr=0x0100, mem_wdata=0x1234, d_wr_ack=1; D fill begins after IDLE.
- d_req, d_addr=0xFFF8 -> issues 0xFFF0..0xFFFE with no wrap past 0xFFFE; d_fill_idx 0..7.
- rst_n low on the cycle of the 3rd fill return -> no further fill strobes or done; a subsequent i_req fills correctly from idx 0.

Source files
------------

// File: rtl/mem_fill_arbiter_if.sv
// Handshake bundle between the I/D cache controllers, the fill arbiter and main memory.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_fill_arbiter_if #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_fill_we;
    logic [IDX_W-1:0]  i_fill_idx;
    logic [DATA_W-1:0] i_fill_data;
    logic              i_done;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              d_wr_ack;
    logic              d_fill_we;
    logic [IDX_W-1:0]  d_fill_idx;
    logic [DATA_W-1:0] d_fill_data;
    logic              d_done;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
               mem_rdata, mem_rvalid,
        output i_fill_we, i_fill_idx, i_fill_data, i_done,
               d_wr_ack, d_fill_we, d_fill_idx, d_fill_data, d_done,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
               mem_rdata, mem_rvalid,
        input  i_fill_we, i_fill_idx, i_fill_data, i_done,
               d_wr_ack, d_fill_we, d_fill_idx, d_fill_data, d_done,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined memory between I-cache fills, D-cache fills and D-side write-through
// stores. Strict D priority, no preemption; every output is registered.
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input logic               clk,
    input logic               rst_n,
    mem_fill_arbiter_if.slave bus
);
    localparam int                IDX_W    = $clog2(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STORE  = 2'd1,
        FILL_D = 2'd2,
        FILL_I = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [IDX_W-1:0]  issueCnt_r;
    logic [IDX_W-1:0]  retCnt_r;
    logic              issuing_r;
    logic              finishing_r;
    logic [IDX_W-1:0]  nextIdx_s;
    logic [ADDR_W-1:0] nextAddr_s;

    function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] addr);
        return addr & ~OFF_MASK;
    endfunction

    // Next issue address; the offset only fills cleared low bits, so it never leaves the block.
    always_comb begin
        nextIdx_s  = issueCnt_r + IDX_W'(1);
        nextAddr_s = base_r + ADDR_W'({nextIdx_s, 1'b0});
    end

    // Arbitration FSM; strobes and bus outputs default low and are only raised while in use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            base_r          <= '0;
            issueCnt_r      <= '0;
            retCnt_r        <= '0;
            issuing_r       <= 1'b0;
            finishing_r     <= 1'b0;
            bus.mem_en      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.d_wr_ack    <= 1'b0;
            bus.i_fill_we   <= 1'b0;
            bus.i_fill_idx  <= '0;
            bus.i_fill_data <= '0;
            bus.i_done      <= 1'b0;
            bus.d_fill_we   <= 1'b0;
            bus.d_fill_idx  <= '0;
            bus.d_fill_data <= '0;
            bus.d_done      <= 1'b0;
        end else begin
            bus.mem_en      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.d_wr_ack    <= 1'b0;
            bus.i_fill_we   <= 1'b0;
            bus.i_fill_idx  <= '0;
            bus.i_fill_data <= '0;
            bus.i_done      <= 1'b0;
            bus.d_fill_we   <= 1'b0;
            bus.d_fill_idx  <= '0;
            bus.d_fill_data <= '0;
            bus.d_done      <= 1'b0;
            case (state_r)
                IDLE: begin
                    issueCnt_r  <= '0;
                    retCnt_r    <= '0;
                    finishing_r <= 1'b0;
                    if (bus.d_wr_req) begin
                        state_r       <= STORE;
                        bus.mem_en    <= 1'b1;
                        bus.mem_wr    <= 1'b1;
                        bus.mem_addr  <= bus.d_wr_addr;
                        bus.mem_wdata <= bus.d_wr_data;
                        bus.d_wr_ack  <= 1'b1;
                    end else if (bus.d_req) begin
                        state_r      <= FILL_D;
                        base_r       <= blockBase(bus.d_addr);
                        issuing_r    <= 1'b1;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= blockBase(bus.d_addr);
                    end else if (bus.i_req) begin
                        state_r      <= FILL_I;
                        base_r       <= blockBase(bus.i_addr);
                        issuing_r    <= 1'b1;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= blockBase(bus.i_addr);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STORE: begin
                    state_r <= IDLE;
                end
                FILL_D, FILL_I: begin
                    // The done cycle is spent here so the requester can drop req before IDLE samples.
                    if (finishing_r) begin
                        state_r     <= IDLE;
                        finishing_r <= 1'b0;
                    end else begin
                        if (issuing_r) begin
                            if (issueCnt_r == LAST_IDX) begin
                                issuing_r <= 1'b0;
                            end else begin
                                issueCnt_r   <= nextIdx_s;
                                bus.mem_en   <= 1'b1;
                                bus.mem_addr <= nextAddr_s;
                            end
                        end
                        if (bus.mem_rvalid) begin
                            if (state_r == FILL_D) begin
                                bus.d_fill_we   <= 1'b1;
                                bus.d_fill_idx  <= retCnt_r;
                                bus.d_fill_data <= bus.mem_rdata;
                                bus.d_done      <= (retCnt_r == LAST_IDX);
                            end else begin
                                bus.i_fill_we   <= 1'b1;
                                bus.i_fill_idx  <= retCnt_r;
                                bus.i_fill_data <= bus.mem_rdata;
                                bus.i_done      <= (retCnt_r == LAST_IDX);
                            end
                            retCnt_r <= retCnt_r + IDX_W'(1);
                            if (retCnt_r == LAST_IDX) begin
                                finishing_r <= 1'b1;
                                issuing_r   <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
